// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with one-byte holding registers per direction and a level interrupt.
// Latency: rdata is combinational; register side effects, UART_TX and irqout update on the next sysclk edge.
// Backpressure: a TXD write while the transmitter is busy is dropped; an unread RX byte is overwritten and flagged.
module uart_mmio #(
    parameter int          CLK_HZ = 50_000_000,
    parameter int          BAUD   = 9600,
    parameter logic [31:0] BASE   = 32'h40000018
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irqout
);

    localparam int              DIV      = CLK_HZ / (BAUD * 16);
    localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [31:0]     RXD_ADDR = BASE + 32'd4;
    localparam logic [31:0]     CON_ADDR = BASE + 32'd8;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

    // Word-granular address decode; the byte offset bits are ignored.
    logic sel_txd, sel_rxd, sel_con;
    assign sel_txd = (addr[31:2] == BASE[31:2]);
    assign sel_rxd = (addr[31:2] == RXD_ADDR[31:2]);
    assign sel_con = (addr[31:2] == CON_ADDR[31:2]);

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    // Control/status state.
    logic       tx_ie, rx_ie, tx_done, rx_valid, rx_ovr, frm_err;
    logic [7:0] txd_reg, rx_data;
    logic       tx_busy, tx_accept;

    // Free-running 16x baud tick generator.
    logic [DIV_W-1:0] baud_cnt;
    logic             tick;
    assign tick = (baud_cnt == DIV_LAST);

    // Baud counter wraps at DIV-1 and pulses tick on the wrap cycle.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) baud_cnt <= '0;
        else if (tick) baud_cnt <= '0;
        else baud_cnt <= baud_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    st_t        tx_state, tx_state_nxt;
    logic [3:0] tx_tick, tx_tick_nxt;
    logic [2:0] tx_bit, tx_bit_nxt;
    logic [7:0] tx_shift, tx_shift_nxt;
    logic       tx_line_nxt, tx_done_set;

    assign tx_busy   = (tx_state != S_IDLE);
    assign tx_accept = wr & sel_txd & ~tx_busy;

    // TX next-state: each bit holds for 16 ticks; line level follows the next state.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_tick_nxt  = tx_tick;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_done_set  = 1'b0;
        tx_line_nxt  = 1'b1;
        case (tx_state)
            S_IDLE: if (tx_accept) begin
                tx_state_nxt = S_START;
                tx_tick_nxt  = 4'd0;
                tx_shift_nxt = wdata[7:0];
            end
            S_START: if (tick) begin
                if (tx_tick == 4'd15) begin
                    tx_state_nxt = S_DATA;
                    tx_bit_nxt   = 3'd0;
                end
                tx_tick_nxt = tx_tick + 4'd1;
            end
            S_DATA: if (tick) begin
                if (tx_tick == 4'd15) begin
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_nxt = S_STOP;
                    else tx_bit_nxt = tx_bit + 3'd1;
                end
                tx_tick_nxt = tx_tick + 4'd1;
            end
            S_STOP: if (tick) begin
                if (tx_tick == 4'd15) begin
                    tx_state_nxt = S_IDLE;
                    tx_done_set  = 1'b1;
                end
                tx_tick_nxt = tx_tick + 4'd1;
            end
            default: tx_state_nxt = S_IDLE;
        endcase
        case (tx_state_nxt)
            S_START: tx_line_nxt = 1'b0;
            S_DATA:  tx_line_nxt = tx_shift_nxt[0];
            default: tx_line_nxt = 1'b1;
        endcase
    end

    // TX state register and registered serial output (idles high).
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_tick  <= 4'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            UART_TX  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_tick  <= tx_tick_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            UART_TX  <= tx_line_nxt;
        end
    end

    // ---------------- receiver ----------------
    logic       rx_meta, rxs;
    st_t        rx_state, rx_state_nxt;
    logic [3:0] rx_tick, rx_tick_nxt;
    logic [2:0] rx_bit, rx_bit_nxt;
    logic [7:0] rx_shift, rx_shift_nxt;
    logic       rx_done, rx_ferr;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) {rxs, rx_meta} <= 2'b00;
        else {rxs, rx_meta} <= {rx_meta, UART_RX};
    end

    // RX next-state: confirm start at mid-bit (8 ticks), then sample every 16 ticks.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_tick_nxt  = rx_tick;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_done      = 1'b0;
        rx_ferr      = 1'b0;
        case (rx_state)
            S_IDLE: if (!rxs) begin
                rx_state_nxt = S_START;
                rx_tick_nxt  = 4'd0;
            end
            S_START: if (tick) begin
                if (rx_tick == 4'd7) begin
                    rx_tick_nxt = 4'd0;
                    rx_bit_nxt  = 3'd0;
                    rx_state_nxt = rxs ? S_IDLE : S_DATA;
                end else begin
                    rx_tick_nxt = rx_tick + 4'd1;
                end
            end
            S_DATA: if (tick) begin
                if (rx_tick == 4'd15) begin
                    rx_shift_nxt = {rxs, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_nxt = S_STOP;
                    else rx_bit_nxt = rx_bit + 3'd1;
                end
                rx_tick_nxt = rx_tick + 4'd1;
            end
            S_STOP: if (tick) begin
                if (rx_tick == 4'd15) begin
                    rx_state_nxt = S_IDLE;
                    rx_done      = rxs;
                    rx_ferr      = ~rxs;
                end
                rx_tick_nxt = rx_tick + 4'd1;
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_state <= S_IDLE;
            rx_tick  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_tick  <= rx_tick_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    // ---------------- register file ----------------
    logic rd_rxd, rd_con;
    assign rd_rxd = rd & sel_rxd;
    assign rd_con = rd & sel_con;

    // Register updates; hardware set events take priority over read-to-clear.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_ie    <= 1'b0;
            rx_ie    <= 1'b0;
            tx_done  <= 1'b0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            frm_err  <= 1'b0;
            txd_reg  <= 8'd0;
            rx_data  <= 8'd0;
            irqout   <= 1'b0;
        end else begin
            if (wr & sel_con) {rx_ie, tx_ie} <= wdata[1:0];
            if (tx_accept) txd_reg <= wdata[7:0];
            if (tx_done_set) tx_done <= 1'b1;
            else if (rd_con) tx_done <= 1'b0;
            if (rx_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_rxd) begin
                rx_valid <= 1'b0;
            end
            if (rx_done & rx_valid & ~rd_rxd) rx_ovr <= 1'b1;
            else if (rd_con) rx_ovr <= 1'b0;
            if (rx_ferr) frm_err <= 1'b1;
            else if (rd_con) frm_err <= 1'b0;
            irqout <= (tx_done & tx_ie) | (rx_valid & rx_ie);
        end
    end

    // Combinational read mux; zero unless a load hits one of the three words.
    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            if (sel_txd) rdata = {24'd0, txd_reg};
            else if (sel_rxd) rdata = {24'd0, rx_data};
            else if (sel_con) rdata = {25'd0, frm_err, rx_ovr, tx_busy, rx_valid, tx_done, rx_ie, tx_ie};
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
`timescale 1ns/1ps
// Bench for uart_mmio: directed stimulus, read expectations queued and checked by a monitor.
module tb_uart_mmio;
    localparam logic [31:0] TXD = 32'h40000018;
    localparam logic [31:0] RXD = 32'h4000001C;
    localparam logic [31:0] CON = 32'h40000020;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic        rx_drv = 1'b1, loop_en = 1'b0;
    logic        rx_line, uart_tx, irqout;

    assign rx_line = loop_en ? uart_tx : rx_drv;

    uart_mmio #(.CLK_HZ(614_400), .BAUD(9600), .BASE(32'h40000018)) dut (
        .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .UART_RX(rx_line), .UART_TX(uart_tx), .irqout(irqout)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with rd asserted consumes one queued expectation.
    logic [31:0] mon_exp;
    string       mon_tag;
    always @(negedge sysclk) begin
        if (rd) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got %h expected nothing queued", rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check(mon_tag, rdata, mon_exp);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge sysclk); #1;
        wr = 1'b1; addr = a; wdata = d;
        @(posedge sysclk); #1;
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        @(posedge sysclk); #1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        rd = 1'b1; addr = a;
        @(posedge sysclk); #1;
        rd = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge sysclk);
    endtask

    // Drive one 8N1 frame at 64 cycles per bit; a bad stop bit is held low for 40 cycles.
    task automatic send_rx(input logic [7:0] b, input logic stop_ok);
        @(posedge sysclk); #1;
        rx_drv = 1'b0;
        idle(64); #1;
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            idle(64); #1;
        end
        if (stop_ok) begin
            rx_drv = 1'b1;
            idle(64); #1;
        end else begin
            rx_drv = 1'b0;
            idle(40); #1;
            rx_drv = 1'b1;
            idle(24); #1;
        end
        rx_drv = 1'b1;
        idle(40);
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int   t0;
    logic found;
    logic [7:0] pat;

    initial begin
        // 1. reset behaviour, including abort of a frame in flight
        idle(5);
        @(negedge sysclk);
        check("tx_in_reset", 32'(uart_tx), 32'd1);
        check("irq_in_reset", 32'(irqout), 32'd0);
        @(posedge sysclk); #1;
        reset = 1'b1;
        idle(20);
        @(negedge sysclk);
        check("tx_idle", 32'(uart_tx), 32'd1);
        check("irq_idle", 32'(irqout), 32'd0);
        bus_read(CON, 32'h0, "con_reset");
        bus_write(TXD, 32'h00);
        idle(30);
        @(negedge sysclk);
        check("tx_mid_frame_low", 32'(uart_tx), 32'd0);
        reset = 1'b0;
        #1;
        check("tx_reset_abort", 32'(uart_tx), 32'd1);
        idle(3); #1;
        reset = 1'b1;
        idle(100);
        bus_read(CON, 32'h0, "con_after_abort");
        bus_read(TXD, 32'h0, "txd_after_abort");

        // 2. transmit 0x55 with tx interrupt enabled
        bus_write(CON, 32'h1);
        bus_write(TXD, 32'h55);
        found = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge sysclk);
            if (uart_tx == 1'b0) begin
                found = 1'b1;
                t0 = cyc;
            end
        end
        check("tx_start_seen", 32'(found), 32'd1);
        pat = 8'h55;
        for (int k = 0; k < 10; k++) begin
            wait_until(t0 + 64 * k + 30);
            if (k == 0) check("tx_start_bit", 32'(uart_tx), 32'd0);
            else if (k == 9) check("tx_stop_bit", 32'(uart_tx), 32'd1);
            else check($sformatf("tx_data_bit%0d", k - 1), 32'(uart_tx), 32'(pat[k-1]));
            if (k == 2) bus_read(CON, 32'h11, "con_busy");
        end
        wait_until(t0 + 650);
        check("irq_tx_done", 32'(irqout), 32'd1);
        bus_read(CON, 32'h05, "con_tx_done");
        idle(3);
        @(negedge sysclk);
        check("irq_tx_cleared", 32'(irqout), 32'd0);
        bus_read(CON, 32'h01, "con_tx_done_cleared");

        // 3. receive 0xA3 with rx interrupt enabled
        bus_write(CON, 32'h2);
        send_rx(8'hA3, 1'b1);
        @(negedge sysclk);
        check("irq_rx_valid", 32'(irqout), 32'd1);
        bus_read(CON, 32'h0A, "con_rx_valid");
        bus_read(RXD, 32'hA3, "rxd_a3");
        idle(3);
        @(negedge sysclk);
        check("irq_rx_cleared", 32'(irqout), 32'd0);
        bus_read(CON, 32'h02, "con_rx_read");

        // 4. overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(CON, 32'h2A, "con_overrun");
        bus_read(RXD, 32'h22, "rxd_overwritten");
        bus_read(CON, 32'h02, "con_ovr_cleared");

        // 5. start glitch, then framing error
        @(posedge sysclk); #1;
        rx_drv = 1'b0;
        idle(16); #1;
        rx_drv = 1'b1;
        idle(200);
        bus_read(CON, 32'h02, "con_after_glitch");
        send_rx(8'h5A, 1'b0);
        idle(100);
        bus_read(CON, 32'h42, "con_frm_err");
        bus_read(CON, 32'h02, "con_frm_err_cleared");

        // 6. loopback, with a write dropped while busy
        loop_en = 1'b1;
        bus_write(TXD, 32'h00);
        idle(20);
        bus_write(TXD, 32'hFF);
        bus_read(TXD, 32'h00, "txd_busy_write_dropped");
        idle(700);
        bus_read(RXD, 32'h00, "loop_rxd_00");
        bus_read(CON, 32'h06, "con_loop_done");
        bus_write(TXD, 32'hFF);
        idle(700);
        bus_read(RXD, 32'hFF, "loop_rxd_ff");
        bus_read(TXD, 32'hFF, "txd_retry_accepted");

        idle(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
